// File: rtl/mc_pkg.sv
// ============================================================================
// Module   : mc_pkg
// Brief    : Shared encodings for the multicycle MIPS sequencing controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_rtype_funct(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_controller_alu_decode.sv
// ============================================================================
// Module   : alu_decode
// Brief    : Maps a 2-bit aluop and the R-type funct field onto alucontrol.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_funct,
  input  logic [1:0] i_aluop,
  output logic [2:0] o_alucontrol
);

  always_comb begin
    o_alucontrol = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alucontrol = ALU_ADD;
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alucontrol = ALU_ADD;
          FN_SUB:  o_alucontrol = ALU_SUB;
          FN_AND:  o_alucontrol = ALU_AND;
          FN_OR:   o_alucontrol = ALU_OR;
          FN_SLT:  o_alucontrol = ALU_SLT;
          default: o_alucontrol = ALU_ADD;
        endcase
      end
      default: o_alucontrol = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
// Module   : mc_controller
// Brief    : Moore-style multicycle sequencer for the MIPS datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pc_en,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     r_state;
  state_t     w_next;
  logic       w_mem_req;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_regwrite;
  logic [1:0] w_aluop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_mem_req  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_regwrite = 1'b0;
    w_aluop    = ALUOP_ADD;
    iord       = 1'b0;
    pcsrc      = PCSRC_ALU;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    case (r_state)
      FETCH: begin
        w_mem_req = 1'b1;
        alusrcb   = SRCB_FOUR;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
        if (mem_ready) w_next = DECODE;
      end
      DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = is_rtype_funct(funct) ? EXECUTE : TRAP;
          OP_BEQ:       w_next = BRANCH;
          OP_ADDI:      w_next = ADDIEX;
          OP_J:         w_next = JUMP;
          default:      w_next = TRAP;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        // Only lw and sw reach here, so anything that is not lw is a store.
        w_next  = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        w_mem_req = 1'b1;
        iord      = 1'b1;
        if (mem_ready) w_next = MEMWB;
      end
      MEMWB: begin
        w_regwrite = 1'b1;
        memtoreg   = 1'b1;
        w_next     = FETCH;
      end
      MEMWR: begin
        w_mem_req  = 1'b1;
        w_memwrite = 1'b1;
        iord       = 1'b1;
        if (mem_ready) w_next = FETCH;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = ALUOP_FUNCT;
        w_next  = ALUWB;
      end
      ALUWB: begin
        w_regwrite = 1'b1;
        regdst     = 1'b1;
        w_next     = FETCH;
      end
      BRANCH: begin
        alusrca  = 1'b1;
        w_aluop  = ALUOP_SUB;
        pcsrc    = PCSRC_ALUOUT;
        w_branch = 1'b1;
        w_next   = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        w_next  = ADDIWB;
      end
      ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = FETCH;
      end
      JUMP: begin
        pcsrc     = PCSRC_JUMP;
        w_pcwrite = 1'b1;
        w_next    = FETCH;
      end
      TRAP:    w_next = TRAP;
      default: w_next = TRAP;
    endcase
  end

  alu_decode u_alu_decode (
    .i_funct      (funct),
    .i_aluop      (w_aluop),
    .o_alucontrol (alucontrol)
  );

  // Reset low parks the FSM in FETCH, so enables are masked to keep it silent.
  assign mem_req  = w_mem_req  & reset;
  assign memwrite = w_memwrite & reset;
  assign irwrite  = w_irwrite  & reset;
  assign pc_en    = (w_pcwrite | (w_branch & zero)) & reset;
  assign regwrite = w_regwrite & reset;
  assign illegal  = (r_state == TRAP);
  assign state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// Module   : tb_mc_controller
// Brief    : Scoreboard bench for mc_controller with an instruction-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mc_controller;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, memwrite, iord, irwrite, pc_en;
  logic [1:0] pcsrc, alusrcb;
  logic       alusrca;
  logic [2:0] alucontrol;
  logic       regdst, memtoreg, regwrite, illegal;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .memwrite   (memwrite),
    .iord       (iord),
    .irwrite    (irwrite),
    .pc_en      (pc_en),
    .pcsrc      (pcsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .illegal    (illegal),
    .state      (state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       ill, mreq, mw, iord, irw, pce;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] alu;
    logic       rd, m2r, rw;
  } obs_t;

  obs_t exp_q[$];
  obs_t msk_q[$];
  obs_t full_m, rst_m;
  obs_t mon_e, mon_m, mon_a;
  int   vectors = 0;
  int   miscompares = 0;
  int   rdy_mode = 0;   // 1: memory always ready
  int   zero_mode = 0;  // 1: zero forced high, 2: forced low, else random
  int   trap_len = 5;

  function automatic obs_t base(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st  = st;
    o.alu = 3'b010;
    return o;
  endfunction

  function automatic bit rtype_alu(input logic [5:0] f, output logic [2:0] a);
    a = 3'b010;
    case (f)
      6'b100000: a = 3'b010;
      6'b100010: a = 3'b110;
      6'b100100: a = 3'b000;
      6'b100101: a = 3'b001;
      6'b101010: a = 3'b111;
      default:   return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic push(input obs_t e, input obs_t m);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    mem_ready = (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
    zero      = (zero_mode == 1) ? 1'b1 : (zero_mode == 2) ? 1'b0 : 1'($urandom);
  endtask

  task automatic rst_cycle();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    mem_ready = 1'($urandom);
    zero      = 1'($urandom);
    push(base(4'd0), rst_m);
  endtask

  task automatic trap_then_reset();
    obs_t e;
    repeat (trap_len) begin
      step();
      op    = 6'($urandom);
      funct = 6'($urandom);
      e = base(4'd12);
      e.ill = 1'b1;
      push(e, full_m);
    end
    rst_cycle();
  endtask

  // One instruction from fetch to its last cycle; wr_stalls >= 0 fixes the
  // number of not-ready cycles in the store phase.
  task automatic instr(input logic [5:0] iop, input logic [5:0] ifn,
                       input int wr_stalls, input bit abort);
    obs_t e;
    logic [2:0] a;
    int n;
    do begin
      step();
      op    = 6'($urandom);
      funct = 6'($urandom);
      e = base(4'd0);
      e.mreq = 1'b1; e.asb = 2'b01; e.irw = mem_ready; e.pce = mem_ready;
      push(e, full_m);
    end while (!mem_ready);
    step();
    op = iop; funct = ifn;
    e = base(4'd1); e.asb = 2'b11;
    push(e, full_m);
    if (iop == 6'b100011 || iop == 6'b101011) begin
      step();
      e = base(4'd2); e.asa = 1'b1; e.asb = 2'b10;
      push(e, full_m);
      if (iop == 6'b100011) begin
        if (abort) begin
          rst_cycle();
          rst_cycle();
          return;
        end
        do begin
          step();
          e = base(4'd3); e.mreq = 1'b1; e.iord = 1'b1;
          push(e, full_m);
        end while (!mem_ready);
        step();
        e = base(4'd4); e.rw = 1'b1; e.m2r = 1'b1;
        push(e, full_m);
      end else begin
        n = 0;
        do begin
          step();
          if (wr_stalls >= 0) mem_ready = (n >= wr_stalls);
          n++;
          e = base(4'd5); e.mreq = 1'b1; e.mw = 1'b1; e.iord = 1'b1;
          push(e, full_m);
        end while (!mem_ready);
      end
    end else if (iop == 6'b000000 && rtype_alu(ifn, a)) begin
      step();
      e = base(4'd6); e.asa = 1'b1; e.alu = a;
      push(e, full_m);
      step();
      e = base(4'd7); e.rw = 1'b1; e.rd = 1'b1;
      push(e, full_m);
    end else if (iop == 6'b000100) begin
      step();
      e = base(4'd8); e.asa = 1'b1; e.alu = 3'b110; e.pcs = 2'b01; e.pce = zero;
      push(e, full_m);
    end else if (iop == 6'b001000) begin
      step();
      e = base(4'd9); e.asa = 1'b1; e.asb = 2'b10;
      push(e, full_m);
      step();
      e = base(4'd10); e.rw = 1'b1;
      push(e, full_m);
    end else if (iop == 6'b000010) begin
      step();
      e = base(4'd11); e.pcs = 2'b10; e.pce = 1'b1;
      push(e, full_m);
    end else begin
      trap_then_reset();
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_m = msk_q.pop_front();
      mon_a = {state, illegal, mem_req, memwrite, iord, irwrite, pc_en, pcsrc,
               alusrca, alusrcb, alucontrol, regdst, memtoreg, regwrite};
      vectors++;
      if ((mon_a & mon_m) !== (mon_e & mon_m)) begin
        miscompares++;
        $display("FAIL outputs@state%0d t=%0t: got %h expected %h (mask %h)",
                 mon_e.st, $time, mon_a, mon_e, mon_m);
      end
    end
  end

  initial begin
    #2_000_000;
    miscompares++;
    $display("FAIL watchdog: stimulus did not complete, got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

  initial begin
    logic [5:0] ops[8];
    logic [5:0] fns[5];
    logic [5:0] rop, rfn;
    full_m = '1;
    rst_m  = '0;
    rst_m.st = '1; rst_m.ill = 1'b1; rst_m.mreq = 1'b1; rst_m.mw = 1'b1;
    rst_m.irw = 1'b1; rst_m.pce = 1'b1; rst_m.rw = 1'b1;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000,
            6'b000100, 6'b001000, 6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    reset = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

    rst_cycle();
    rst_cycle();
    rdy_mode = 1;
    instr(6'b100011, 6'h15, -1, 1'b0);
    instr(6'b000000, 6'b100000, -1, 1'b0);
    instr(6'b000000, 6'b101010, -1, 1'b0);
    instr(6'b000000, 6'b100100, -1, 1'b0);
    zero_mode = 1;
    instr(6'b000100, 6'h00, -1, 1'b0);
    zero_mode = 2;
    instr(6'b000100, 6'h00, -1, 1'b0);
    zero_mode = 0;
    instr(6'b101011, 6'h07, 3, 1'b0);
    instr(6'b001000, 6'h2a, -1, 1'b0);
    instr(6'b000010, 6'h01, -1, 1'b0);
    trap_len = 20;
    instr(6'b111111, 6'h00, -1, 1'b0);
    instr(6'b000000, 6'b000001, -1, 1'b0);
    instr(6'b100011, 6'h00, -1, 1'b1);
    instr(6'b100011, 6'h00, -1, 1'b0);

    rdy_mode = 0;
    for (int i = 0; i < 250; i++) begin
      trap_len = int'($urandom_range(1, 6));
      if ($urandom_range(0, 15) == 0) rop = 6'($urandom);
      else rop = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) rfn = 6'($urandom);
      else rfn = fns[$urandom_range(0, 4)];
      instr(rop, rfn, -1, ($urandom_range(0, 19) == 0));
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
